// File: rtl/color_config_ctrl.sv
// color_config_ctrl: button-driven paper/letter/tone editor with frame-synchronous commit
// Ports: clk, reset (sync, active-high); btn_sel/btn_next raw buttons; frame_end vblank pulse;
//        color_p/color_l/ton active colour outputs; edit_field current field; pending uncommitted edit
module color_config_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0] TON_STEP        = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sel,
  input  logic       btn_next,
  input  logic       frame_end,
  output logic [2:0] color_p,
  output logic [2:0] color_l,
  output logic [7:0] ton,
  output logic [1:0] edit_field,
  output logic       pending
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {EDIT_P = 2'b00, EDIT_L = 2'b01, EDIT_T = 2'b10} state_t;
  // bit 0 = sel, bit 1 = next
  logic [1:0]    r_s1, r_s2, r_lvl, r_lvl_d;
  logic [CW-1:0] r_cnt [2];
  state_t        r_state;
  logic [2:0]    r_sp, r_sl, r_cp, r_cl;
  logic [7:0]    r_st, r_ct;
  logic          r_pending;
  logic [1:0]    w_press;
  logic          w_sel, w_next, w_chg;
  logic [2:0]    w_p1, w_l1, w_np, w_nl;
  logic [7:0]    w_nt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= {btn_next, btn_sel};
      r_s2    <= r_s1;
      r_lvl_d <= r_lvl;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_lvl[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_lvl[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
  // Press pulse on debounced rising edge only; paper and letter skip over each other
  always_comb begin
    w_press = r_lvl & ~r_lvl_d;
    w_sel   = w_press[0];
    w_next  = w_press[1];
    w_p1    = r_sp + 3'd1;
    w_l1    = r_sl + 3'd1;
    w_np    = (w_p1 == r_sl) ? w_p1 + 3'd1 : w_p1;
    w_nl    = (w_l1 == r_sp) ? w_l1 + 3'd1 : w_l1;
    w_nt    = r_st + TON_STEP;
    w_chg   = w_next && (r_state != EDIT_T || w_nt != r_st);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= EDIT_P;
      r_sp      <= 3'b000;
      r_sl      <= 3'b111;
      r_st      <= 8'hFF;
      r_cp      <= 3'b000;
      r_cl      <= 3'b111;
      r_ct      <= 8'hFF;
      r_pending <= 1'b0;
    end else begin
      // commit samples the shadows before any same-cycle edit lands
      if (frame_end && r_pending) begin
        r_cp <= r_sp;
        r_cl <= r_sl;
        r_ct <= r_st;
      end
      r_pending <= w_chg || (r_pending && !frame_end);
      r_sp      <= (w_next && r_state == EDIT_P) ? w_np : r_sp;
      r_sl      <= (w_next && r_state == EDIT_L) ? w_nl : r_sl;
      r_st      <= (w_next && r_state == EDIT_T) ? w_nt : r_st;
      r_state   <= !w_sel ? r_state : r_state == EDIT_P ? EDIT_L : r_state == EDIT_L ? EDIT_T : EDIT_P;
    end
  end
  assign color_p    = r_cp;
  assign color_l    = r_cl;
  assign ton        = r_ct;
  assign edit_field = r_state;
  assign pending    = r_pending;
endmodule

// File: tb/tb_color_config_ctrl.sv
// tb_color_config_ctrl: directed and randomized checks of color_config_ctrl against a behavioural model
module tb_color_config_ctrl;
  logic       clk = 1'b0, reset = 1'b1, btn_sel = 1'b0, btn_next = 1'b0, frame_end = 1'b0;
  logic [2:0] color_p, color_l;
  logic [7:0] ton;
  logic [1:0] edit_field;
  logic       pending;
  int checks = 0, errors = 0;
  int m_p, m_l, m_t, m_f, a_p, a_l, a_t;
  int m_pend;
  color_config_ctrl #(.DEBOUNCE_CYCLES(4), .TON_STEP(8'h01)) dut (
    .clk(clk), .reset(reset), .btn_sel(btn_sel), .btn_next(btn_next), .frame_end(frame_end),
    .color_p(color_p), .color_l(color_l), .ton(ton), .edit_field(edit_field), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".color_p"}, 8'(color_p), 8'(a_p));
    chk({tag, ".color_l"}, 8'(color_l), 8'(a_l));
    chk({tag, ".ton"}, ton, 8'(a_t));
    chk({tag, ".edit_field"}, 8'(edit_field), 8'(m_f));
    chk({tag, ".pending"}, 8'(pending), 8'(m_pend));
  endtask
  task automatic m_reset();
    m_p = 0; m_l = 7; m_t = 255; m_f = 0; m_pend = 0;
    a_p = 0; a_l = 7; a_t = 255;
  endtask
  task automatic m_next();
    if (m_f == 0) begin
      m_p = (m_p + 1) % 8;
      if (m_p == m_l) m_p = (m_p + 1) % 8;
    end else if (m_f == 1) begin
      m_l = (m_l + 1) % 8;
      if (m_l == m_p) m_l = (m_l + 1) % 8;
    end else m_t = (m_t + 1) % 256;
    m_pend = 1;
  endtask
  task automatic m_sel();
    m_f = (m_f + 1) % 3;
  endtask
  task automatic m_commit();
    if (m_pend != 0) begin
      a_p = m_p; a_l = m_l; a_t = m_t; m_pend = 0;
    end
  endtask
  task automatic press(input bit s, input bit n);
    btn_sel = s; btn_next = n;
    cyc(10);
    btn_sel = 0; btn_next = 0;
    cyc(8);
    if (n) m_next();
    if (s) m_sel();
  endtask
  task automatic frame();
    frame_end = 1;
    cyc(1);
    frame_end = 0;
    m_commit();
  endtask
  task automatic do_reset();
    reset = 1;
    cyc(2);
    reset = 0;
    m_reset();
  endtask
  initial begin
    m_reset();
    cyc(1);
    do_reset();
    chk_all("reset");
    chk("reset.ton_ff", ton, 8'hFF);
    btn_next = 1;
    cyc(3);
    btn_next = 0;
    cyc(10);
    chk_all("bounce");
    btn_next = 1;
    cyc(6);
    chk("latency.before", 8'(pending), 8'd0);
    cyc(1);
    chk("latency.at_L", 8'(pending), 8'd1);
    cyc(3);
    btn_next = 0;
    cyc(8);
    m_next();
    chk_all("held_press");
    chk("held.color_p_unchanged", 8'(color_p), 8'd0);
    frame();
    chk_all("commit1");
    chk("commit1.color_p", 8'(color_p), 8'd1);
    frame();
    chk_all("commit2_nochange");
    repeat (5) press(0, 1);
    frame();
    chk("paper_at_6", 8'(color_p), 8'd6);
    press(0, 1);
    frame();
    chk_all("paper_skip");
    chk("paper_skip.color_p", 8'(color_p), 8'd0);
    press(1, 0);
    press(0, 1);
    frame();
    chk_all("letter_wrap");
    chk("letter_wrap.color_l", 8'(color_l), 8'd1);
    press(1, 0);
    chk("tone_field", 8'(edit_field), 8'd2);
    press(0, 1);
    frame();
    chk_all("tone_wrap");
    chk("tone_wrap.ton", ton, 8'h00);
    press(1, 0);
    chk_all("field_wrap");
    press(0, 1);
    chk_all("pre_combo");
    btn_sel = 1; btn_next = 1;
    cyc(6);
    frame_end = 1;
    cyc(1);
    frame_end = 0;
    m_commit();
    m_next();
    m_sel();
    cyc(3);
    btn_sel = 0; btn_next = 0;
    cyc(8);
    chk_all("combo");
    chk("combo.edit_field", 8'(edit_field), 8'd1);
    btn_next = 1;
    cyc(3);
    reset = 1;
    btn_next = 0;
    cyc(2);
    reset = 0;
    m_reset();
    cyc(12);
    chk_all("reset_mid_debounce");
    btn_next = 1;
    cyc(3);
    reset = 1;
    cyc(2);
    reset = 0;
    m_reset();
    cyc(12);
    btn_next = 0;
    cyc(8);
    m_next();
    chk_all("held_through_reset");
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 4))
        0: press(1, 0);
        1, 2: press(0, 1);
        3: frame();
        default: begin
          btn_next = 1;
          cyc($urandom_range(1, 3));
          btn_next = 0;
          cyc(8);
        end
      endcase
      chk_all($sformatf("rand%0d", k));
    end
    frame();
    chk_all("final_commit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
